// File: rtl/lipsi_mem_arbiter_if.sv
// rtl/lipsi_mem_arbiter_if.sv - request/grant/read-data bundle for one port of the Lipsi memory arbiter
//
// One instance per requester.
//   master modport (requester side) drives: req, we, addr, wdata
//                                  samples: gnt, rvalid, rdata
//   slave modport (arbiter side) is the mirror image.
//   req    : access request, level, held until gnt
//   we     : 1 = write, 0 = read
//   addr   : byte address
//   wdata  : write data
//   gnt    : one-cycle grant pulse (the access cycle)
//   rvalid : one-cycle read-data-valid pulse, the cycle after gnt of a read
//   rdata  : last read data for this port
interface lipsi_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lipsi_mem_arbiter.sv
// rtl/lipsi_mem_arbiter.sv - 2-port round-robin arbiter owning the Lipsi 2**ADDR_W x DATA_W data memory
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-low
//   c0        : port 0 (Lipsi CPU data port), lipsi_mem_arbiter_if.slave
//   c1        : port 1 (host/debug port),     lipsi_mem_arbiter_if.slave
//   busy      : high during the single ACCESS cycle
//   conflicts : saturating count of IDLE cycles with both requests high
//
// Build option: define LIPSI_ARB_FIXED_PRIO_EN to make port 0 always win on
// contention (port 1 may starve). Undefined: round-robin.
module lipsi_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  lipsi_mem_arbiter_if.slave    c0,
  lipsi_mem_arbiter_if.slave    c1,
  output logic                  busy,
  output logic [CNT_W-1:0]      conflicts
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_gnt_q, last_gnt_d;
  logic              conflict;
  logic [CNT_W-1:0]  conflicts_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              do_access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // Operands come straight from the selected port; requesters hold them
  // stable until their grant cycle ends.
  assign do_access = (state_q == ACCESS);
  assign acc_we    = sel_q ? c1.we    : c0.we;
  assign acc_addr  = sel_q ? c1.addr  : c0.addr;
  assign acc_wdata = sel_q ? c1.wdata : c0.wdata;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    conflict   = 1'b0;
    case (state_q)
      IDLE: begin
        if (c0.req && c1.req) begin
          conflict = 1'b1;
`ifdef LIPSI_ARB_FIXED_PRIO_EN
          sel_d = 1'b0;
`else
          sel_d = ~last_gnt_q;
`endif
        end else if (c1.req) begin
          sel_d = 1'b1;
        end else begin
          sel_d = 1'b0;
        end
        if (c0.req || c1.req) begin
          last_gnt_d = sel_d;
          state_d    = ACCESS;
        end
      end
      ACCESS: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_gnt_q  <= 1'b1;  // port 0 wins the first contention
      conflicts_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      if (conflict && (conflicts_q != {CNT_W{1'b1}})) begin
        conflicts_q <= conflicts_q + 1'b1;
      end
      rvalid0_q <= do_access && !acc_we && !sel_q;
      rvalid1_q <= do_access && !acc_we &&  sel_q;
      if (do_access && !acc_we) begin
        if (sel_q) rdata1_q <= mem[acc_addr];
        else       rdata0_q <= mem[acc_addr];
      end
    end
  end

  // Memory is never cleared; a reset during ACCESS suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && do_access && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  assign c0.gnt    = do_access && !sel_q;
  assign c1.gnt    = do_access &&  sel_q;
  assign c0.rvalid = rvalid0_q;
  assign c1.rvalid = rvalid1_q;
  assign c0.rdata  = rdata0_q;
  assign c1.rdata  = rdata1_q;
  assign busy      = do_access;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_lipsi_mem_arbiter.sv
// tb/tb_lipsi_mem_arbiter.sv - scoreboard testbench for lipsi_mem_arbiter
module tb_lipsi_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 8;
`ifdef LIPSI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          busy;
  logic [CW-1:0] conflicts;

  lipsi_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c0 ();
  lipsi_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c1 ();

  lipsi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .c0(c0), .c1(c1), .busy(busy), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit port; } gev_t;
  typedef struct { int cyc; logic [7:0] data; } rev_t;
  gev_t gq[$];
  rev_t rq0[$];
  rev_t rq1[$];

  logic [7:0] mdl_mem [256];
  bit         mdl_last = 1'b1;
  int         mdl_conf = 0;
  logic [7:0] exp_rd [2];
  int         n_tests = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) next_cyc();
  endtask

  task automatic drive(input bit p, input bit rq, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (!p) begin c0.req = rq; c0.we = we; c0.addr = a; c0.wdata = d; end
    else    begin c1.req = rq; c1.we = we; c1.addr = a; c1.wdata = d; end
  endtask

  task automatic drop(input bit p);
    if (!p) c0.req = 1'b0; else c1.req = 1'b0;
  endtask

  task automatic bump_conf();
    if (mdl_conf < 255) mdl_conf++;
  endtask

  // Reference: a grant at cycle gc performs the op on the model memory in grant order.
  task automatic model_grant(input bit p, input int gc, input bit we, input logic [7:0] a, input logic [7:0] d);
    gev_t g;
    rev_t r;
    g.cyc = gc; g.port = p;
    gq.push_back(g);
    mdl_last = p;
    if (we) mdl_mem[a] = d;
    else begin
      r.cyc = gc + 1; r.data = mdl_mem[a];
      if (p) rq1.push_back(r); else rq0.push_back(r);
    end
  endtask

  task automatic single(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d);
    int k;
    k = cyc;
    drive(p, 1'b1, we, a, d);
    model_grant(p, k + 1, we, a, d);
    wait_cyc(k + 2);
    drop(p);
  endtask

  task automatic pair(input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                      input bit we1, input logic [7:0] a1, input logic [7:0] d1);
    int k;
    bit w;
    bit we_[2];
    logic [7:0] a_[2];
    logic [7:0] d_[2];
    we_[0] = we0; a_[0] = a0; d_[0] = d0;
    we_[1] = we1; a_[1] = a1; d_[1] = d1;
    k = cyc;
    drive(1'b0, 1'b1, we0, a0, d0);
    drive(1'b1, 1'b1, we1, a1, d1);
    w = FIXED ? 1'b0 : ~mdl_last;
    bump_conf();
    model_grant(w, k + 1, we_[w], a_[w], d_[w]);
    model_grant(~w, k + 3, we_[~w], a_[~w], d_[~w]);
    wait_cyc(k + 2);
    drop(w);
    wait_cyc(k + 4);
    drop(~w);
  endtask

  // Both requests held for n consecutive arbitration rounds.
  task automatic contend(input int n, input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                         input bit we1, input logic [7:0] a1, input logic [7:0] d1);
    int k;
    bit p;
    k = cyc;
    drive(1'b0, 1'b1, we0, a0, d0);
    drive(1'b1, 1'b1, we1, a1, d1);
    for (int i = 0; i < n; i++) begin
      p = FIXED ? 1'b0 : ~mdl_last;
      bump_conf();
      if (p) model_grant(1'b1, k + 1 + 2 * i, we1, a1, d1);
      else   model_grant(1'b0, k + 1 + 2 * i, we0, a0, d0);
    end
    wait_cyc(k + 2 * n);
    drop(1'b0);
    drop(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next_cyc();
    exp_rd[0] = '0; exp_rd[1] = '0;
    mdl_last = 1'b1;
    mdl_conf = 0;
    next_cyc();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    bit e0, e1, r0, r1;
    if (mon_en) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        chk("gnt_missed", 0, 1);
        void'(gq.pop_front());
      end
      while (rq0.size() > 0 && rq0[0].cyc < cyc) begin
        chk("c0_rvalid_missed", 0, 1);
        void'(rq0.pop_front());
      end
      while (rq1.size() > 0 && rq1[0].cyc < cyc) begin
        chk("c1_rvalid_missed", 0, 1);
        void'(rq1.pop_front());
      end
      e0 = (gq.size() > 0) && (gq[0].cyc == cyc) && !gq[0].port;
      e1 = (gq.size() > 0) && (gq[0].cyc == cyc) &&  gq[0].port;
      chk("c0_gnt", int'(c0.gnt), int'(e0));
      chk("c1_gnt", int'(c1.gnt), int'(e1));
      chk("busy", int'(busy), int'(e0 | e1));
      if (e0 || e1) void'(gq.pop_front());
      r0 = (rq0.size() > 0) && (rq0[0].cyc == cyc);
      r1 = (rq1.size() > 0) && (rq1[0].cyc == cyc);
      chk("c0_rvalid", int'(c0.rvalid), int'(r0));
      chk("c1_rvalid", int'(c1.rvalid), int'(r1));
      if (r0) begin exp_rd[0] = rq0[0].data; void'(rq0.pop_front()); end
      if (r1) begin exp_rd[1] = rq1[0].data; void'(rq1.pop_front()); end
      chk("c0_rdata", int'(c0.rdata), int'(exp_rd[0]));
      chk("c1_rdata", int'(c1.rdata), int'(exp_rd[1]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected done", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n;
    exp_rd[0] = '0; exp_rd[1] = '0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    repeat (3) next_cyc();
    reset = 1'b1;
    mon_en = 1'b1;
    chk("reset_conflicts", int'(conflicts), 0);

    // single write/read on port 1
    single(1'b1, 1'b1, 8'h05, 8'hA7);
    single(1'b1, 1'b0, 8'h05, 8'h00);
    next_cyc();
    chk("t1_rdata", int'(c1.rdata), 'hA7);

    // first contention after reset: port 0 read, port 1 write
    pair(1'b0, 8'h05, 8'h00, 1'b1, 8'h05, 8'h3C);
    chk("t2_conflicts", int'(conflicts), 1);
    chk("t2_c0_rdata", int'(c0.rdata), 'hA7);
    single(1'b0, 1'b0, 8'h05, 8'h00);
    next_cyc();
    chk("t2_readback", int'(c0.rdata), 'h3C);

    // preload every address through the host port
    for (int a = 0; a < 256; a++) single(1'b1, 1'b1, 8'(a), 8'($urandom_range(0, 255)));
    single(1'b1, 1'b1, 8'h10, 8'hC3);

    // sustained contention, 6 grants
    do_reset();
    contend(6, 1'b0, 8'h05, 8'h00, 1'b1, 8'h06, 8'h11);
    chk("t3_conflicts", int'(conflicts), 6);

    // saturation
    contend(260, 1'b1, 8'h20, 8'h5A, 1'b0, 8'h21, 8'h00);
    chk("sat_conflicts", int'(conflicts), 255);
    pair(1'b0, 8'h20, 8'h00, 1'b0, 8'h06, 8'h00);
    chk("sat_hold", int'(conflicts), 255);

    // reset during the ACCESS cycle of a write
    begin
      int k;
      gev_t g;
      k = cyc;
      drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h55);
      g.cyc = k + 1; g.port = 1'b0;
      gq.push_back(g);
      wait_cyc(k + 1);
      reset = 1'b0;
      wait_cyc(k + 2);
      reset = 1'b1;
      drop(1'b0);
      exp_rd[0] = '0; exp_rd[1] = '0;
      mdl_last = 1'b1;
      mdl_conf = 0;
    end
    chk("rst_conflicts", int'(conflicts), 0);
    single(1'b1, 1'b0, 8'h10, 8'h00);
    next_cyc();
    chk("rst_no_write", int'(c1.rdata), 'hC3);

    // boundary addresses
    single(1'b0, 1'b1, 8'hFF, 8'h81);
    single(1'b1, 1'b1, 8'h00, 8'h7E);
    single(1'b0, 1'b0, 8'hFF, 8'h00);
    single(1'b1, 1'b0, 8'h00, 8'h00);
    next_cyc();
    chk("bnd_ff", int'(c0.rdata), 'h81);
    chk("bnd_00", int'(c1.rdata), 'h7E);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end else if (kind == 1) begin
        pair(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end else begin
        n = $urandom_range(2, 4);
        contend(n, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      chk("rand_conflicts", int'(conflicts), mdl_conf);
      repeat ($urandom_range(0, 2)) next_cyc();
    end

    wait_cyc(cyc + 4);
    chk("gq_drained", gq.size(), 0);
    chk("rq0_drained", rq0.size(), 0);
    chk("rq1_drained", rq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lipsi_mem_arbiter.md
Name: lipsi_mem_arbiter

Overview:
- Owns the 256x8 Lipsi data memory and shares it between two requesters.
- Port 0 is the Lipsi processor's data-memory port. Port 1 is a host/debug port used for preloading and inspecting memory.
- Single-port memory, one access per grant.
- Round-robin arbitration on contention, plus a saturating contention counter for debug display.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 8, data width.
- CNT_W, 8, width of the contention counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- c0_req  input  1  port 0 (CPU) access request; level, held until c0_gnt.
- c0_we  input  1  port 0 write enable (1=write, 0=read).
- c0_addr  input  ADDR_W  port 0 address.
- c0_wdata  input  DATA_W  port 0 write data.
- c0_gnt  output  1  port 0 grant, one-cycle pulse.
- c0_rvalid  output  1  port 0 read data valid, one-cycle pulse.
- c0_rdata  output  DATA_W  port 0 read data.
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: port 1 (host); same as port 0.
- busy  output  1  high while the FSM is in ACCESS.
- conflicts  output  CNT_W  count of cycles where both requests were high in IDLE; saturates.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; last_gnt=1, so port 0 wins the first contention.
  - All gnt/rvalid=0; rdata=0; busy=0; conflicts=0.
  - Memory contents are not cleared.
  - Reset mid-ACCESS aborts the access with no write, and no rvalid follows.
- FSM states IDLE, ACCESS.
- IDLE:
  - No req: stay IDLE.
  - Exactly one req: select that port.
  - Both reqs: select the port != last_gnt, and increment conflicts unless it is all ones.
  - On any selection: store sel, update last_gnt=sel, go to ACCESS.
- ACCESS (exactly one cycle):
  - gnt_sel=1 and busy=1.
  - The memory operation uses the selected port's we/addr/wdata as sampled on this cycle's clk edge. Requesters keep these stable from req rise through the gnt cycle.
  - Write: mem[addr] <= wdata at the end of the ACCESS cycle.
  - Read: rdata_sel <= mem[addr]; rvalid_sel=1 in the following cycle (IDLE).
  - Always returns to IDLE.
- Latency:
  - req seen in IDLE at cycle N -> gnt in cycle N+1 -> rvalid/rdata in cycle N+2.
  - Minimum gap between grants is 2 cycles (max throughput 1 access / 2 cycles).
- Losing requester keeps req high. It is guaranteed the next grant: round-robin, so wait is at most one access.
- req still high in the IDLE cycle after its own gnt is a new request. Requesters must drop req in the cycle after gnt.
- rdata_x holds its last read value until the next read on that port. Writes do not change rdata.
- Read-after-write to the same address from either port returns the new data. Accesses are serialized, so there is no bypass hazard.
- Write and rvalid are never generated for the unselected port.
- Address wrap: none. Full ADDR_W range is valid. Address 2**ADDR_W-1 is ordinary memory.
- gnt signals are mutually exclusive. So are rvalid signals. gnt and rvalid never coincide on the same port.

Optional Feature:
- LIPSI_ARB_FIXED_PRIO_EN.
- Defined: on contention port 0 (CPU) always wins; last_gnt is ignored. Port 1 can starve while the CPU streams back-to-back requests. conflicts still counts.
- Undefined: round-robin as above.

Test Plan:
- Reset then single write/read: c1 write addr 0x05 data 0xA7.
  - c1_gnt one cycle after req.
  - Then c1 read 0x05 -> c1_rvalid pulse two cycles after req, c1_rdata=0xA7.
  - c0 outputs stay 0 throughout.
- Contention after reset: c0 and c1 both request in the same cycle (c0 read 0x05, c1 write 0x05=0x3C).
  - c0_gnt first, c0_rdata=0xA7.
  - c1_gnt two cycles after c0_gnt; subsequent read returns 0x3C.
  - conflicts=1.
- Sustained contention for 6 grants: grants alternate c0,c1,c0,c1,c0,c1. Or with LIPSI_ARB_FIXED_PRIO_EN: all c0 while c0_req is re-asserted each IDLE, c1 never granted. conflicts=6.
- Saturation: force 260 contention cycles -> conflicts=0xFF and stays at 0xFF.
- Reset mid-access: c0 write 0x10=0x55 with reset low during the ACCESS cycle.
  - After release, a read of 0x10 returns its pre-reset value, not 0x55.
  - No rvalid pulses; conflicts=0.
- Boundary address: write 0xFF=0x81, write 0x00=0x7E. Read both back -> 0x81, 0x7E, with no aliasing.
